// File: rtl/pisa_vga_pkg.sv
// Shared types and constants for the PISA/VGA image RAM read path.
package pisa_vga_pkg;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        HDR2,
        HDR3,
        HDR_WAIT,
        RUN
    } arb_state_t;

    typedef enum logic [2:0] {
        TAG_NONE,
        TAG_HDR0,
        TAG_HDR1,
        TAG_HDR2,
        TAG_HDR3,
        TAG_DISP,
        TAG_PROC
    } rd_tag_t;

    // Header layout: big-endian 16-bit width at 0..1, height at 4..5
    localparam int HDR_ADDR_W_HI = 0;
    localparam int HDR_ADDR_W_LO = 1;
    localparam int HDR_ADDR_H_HI = 4;
    localparam int HDR_ADDR_H_LO = 5;

endpackage

// File: rtl/rd_tag_pipe.sv
// Tag delay line that tracks each issued RAM read until its data returns.
module rd_tag_pipe
    import pisa_vga_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    flush_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (!flush_n) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= TAG_NONE;
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/vga_ram_read_arbiter.sv
// Image RAM read-port arbiter: loads the image header, then shares the port
// between the display fetcher (priority) and the processor (bounded starvation).
module vga_ram_read_arbiter
    import pisa_vga_pkg::*;
#(
    parameter int                ADDR_W       = 18,
    parameter int                DATA_W       = 8,
    parameter int                RD_LAT       = 1,
    parameter logic [ADDR_W-1:0] BASE_ADDRESS = 'h10,
    parameter int                STARVE_MAX   = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] ram_rdaddress,
    input  logic [DATA_W-1:0] ram_q,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              proc_req,
    input  logic [ADDR_W-1:0] proc_addr,
    output logic              proc_gnt,
    output logic              proc_rvalid,
    output logic [DATA_W-1:0] proc_rdata,
    output logic [15:0]       img_width,
    output logic [15:0]       img_height,
    output logic              hdr_valid
);

    arb_state_t        state, state_nxt;
    rd_tag_t           tag_issue, tag_ret;
    logic [ADDR_W-1:0] addr_nxt;
    logic [3:0]        starve_cnt;
    logic              starve_hit;

    assign starve_hit = (starve_cnt == 4'(STARVE_MAX));

    rd_tag_pipe #(.DEPTH(RD_LAT + 1)) u_tag_pipe (
        .clk     (clk),
        .flush_n (rst),
        .tag_in  (tag_issue),
        .tag_out (tag_ret)
    );

    always_comb begin
        state_nxt = state;
        tag_issue = TAG_NONE;
        addr_nxt  = ram_rdaddress;
        disp_gnt  = 1'b0;
        proc_gnt  = 1'b0;
        case (state)
            HDR0: begin
                state_nxt = HDR1;
                tag_issue = TAG_HDR0;
                addr_nxt  = ADDR_W'(HDR_ADDR_W_HI);
            end
            HDR1: begin
                state_nxt = HDR2;
                tag_issue = TAG_HDR1;
                addr_nxt  = ADDR_W'(HDR_ADDR_W_LO);
            end
            HDR2: begin
                state_nxt = HDR3;
                tag_issue = TAG_HDR2;
                addr_nxt  = ADDR_W'(HDR_ADDR_H_HI);
            end
            HDR3: begin
                state_nxt = HDR_WAIT;
                tag_issue = TAG_HDR3;
                addr_nxt  = ADDR_W'(HDR_ADDR_H_LO);
            end
            HDR_WAIT: begin
                if (tag_ret == TAG_HDR3) state_nxt = RUN;
            end
            RUN: begin
                // rst gating keeps grants low during the reset cycle itself
                if (rst && hdr_valid) begin
                    if (disp_req && !(proc_req && starve_hit)) begin
                        disp_gnt  = 1'b1;
                        tag_issue = TAG_DISP;
                        addr_nxt  = disp_addr + BASE_ADDRESS;
                    end else if (proc_req) begin
                        proc_gnt  = 1'b1;
                        tag_issue = TAG_PROC;
                        addr_nxt  = proc_addr;
                    end
                end
            end
            default: state_nxt = HDR0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= HDR0;
            ram_rdaddress <= '0;
            starve_cnt    <= '0;
        end else begin
            state         <= state_nxt;
            ram_rdaddress <= addr_nxt;
            if (!proc_req || proc_gnt)
                starve_cnt <= '0;
            else if (disp_gnt && !starve_hit)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            disp_rvalid <= 1'b0;
            proc_rvalid <= 1'b0;
            disp_rdata  <= '0;
            proc_rdata  <= '0;
            img_width   <= '0;
            img_height  <= '0;
            hdr_valid   <= 1'b0;
        end else begin
            disp_rvalid <= (tag_ret == TAG_DISP);
            proc_rvalid <= (tag_ret == TAG_PROC);
            if (tag_ret == TAG_DISP) disp_rdata <= ram_q;
            if (tag_ret == TAG_PROC) proc_rdata <= ram_q;
            // header fields freeze once captured
            if (!hdr_valid) begin
                case (tag_ret)
                    TAG_HDR0: img_width[15:8]  <= 8'(ram_q);
                    TAG_HDR1: img_width[7:0]   <= 8'(ram_q);
                    TAG_HDR2: img_height[15:8] <= 8'(ram_q);
                    TAG_HDR3: begin
                        img_height[7:0] <= 8'(ram_q);
                        hdr_valid       <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_ram_read_arbiter.sv
// Scoreboard bench for vga_ram_read_arbiter: directed vectors, queued expectations.
module tb_vga_ram_read_arbiter;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 1;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] ram_rdaddress;
    logic [DATA_W-1:0] ram_q;
    logic              disp_req = 1'b0;
    logic [ADDR_W-1:0] disp_addr = '0;
    logic              disp_gnt, disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic              proc_req = 1'b0;
    logic [ADDR_W-1:0] proc_addr = '0;
    logic              proc_gnt, proc_rvalid;
    logic [DATA_W-1:0] proc_rdata;
    logic [15:0]       img_width, img_height;
    logic              hdr_valid;

    vga_ram_read_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT),
        .BASE_ADDRESS(18'h10), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .ram_rdaddress(ram_rdaddress), .ram_q(ram_q),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .proc_req(proc_req), .proc_addr(proc_addr), .proc_gnt(proc_gnt),
        .proc_rvalid(proc_rvalid), .proc_rdata(proc_rdata),
        .img_width(img_width), .img_height(img_height), .hdr_valid(hdr_valid)
    );

    always #5 clk = ~clk;

    // Image RAM: header 64x64, other bytes a fixed scramble of the address
    function automatic logic [7:0] ram_byte(input logic [17:0] a);
        case (a)
            18'd0:   return 8'h00;
            18'd1:   return 8'h40;
            18'd4:   return 8'h00;
            18'd5:   return 8'h40;
            default: return a[7:0] ^ a[15:8] ^ {6'b0, a[17:16]} ^ 8'hA5;
        endcase
    endfunction

    always @(posedge clk) ram_q <= ram_byte(ram_rdaddress);

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t dq[$];
    exp_t pq[$];
    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [17:0] last_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_d(input logic [17:0] ram_addr);
        exp_t e;
        e.data = ram_byte(ram_addr);
        e.due  = cyc + RD_LAT + 2;
        dq.push_back(e);
    endtask

    task automatic push_p(input logic [17:0] ram_addr);
        exp_t e;
        e.data = ram_byte(ram_addr);
        e.due  = cyc + RD_LAT + 2;
        pq.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (disp_rvalid) begin
                if (dq.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL disp_rvalid_unexpected: rdata %0h at cycle %0d, none expected", disp_rdata, cyc);
                end else begin
                    e = dq.pop_front();
                    chk("disp_rdata", disp_rdata, e.data);
                    chk("disp_latency", cyc, e.due);
                end
            end
            if (proc_rvalid) begin
                if (pq.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL proc_rvalid_unexpected: rdata %0h at cycle %0d, none expected", proc_rdata, cyc);
                end else begin
                    e = pq.pop_front();
                    chk("proc_rdata", proc_rdata, e.data);
                    chk("proc_latency", cyc, e.due);
                end
            end
        end
    endtask

    // Entered in cycle 0 after reset release with disp_req=1, disp_addr=0 held.
    task automatic header_check();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("hdr_valid_early", hdr_valid, 0);
            chk("gnt_before_hdr", {disp_gnt, proc_gnt}, 0);
            tick();
        end
        @(negedge clk);
        chk("hdr_valid_c6", hdr_valid, 1);
        chk("img_width", img_width, 16'd64);
        chk("img_height", img_height, 16'd64);
        chk("disp_gnt_c6", disp_gnt, 1);
        push_d(18'h10);
        last_addr = 18'h10;
    endtask

    initial begin
        fork
            monitor();
        join_none

        // reset state
        repeat (3) tick();
        disp_req = 1'b1;
        disp_addr = '0;
        @(negedge clk);
        chk("rst_rdaddress", ram_rdaddress, 0);
        chk("rst_gnt", {disp_gnt, proc_gnt}, 0);
        chk("rst_rvalid", {disp_rvalid, proc_rvalid}, 0);
        chk("rst_rdata", {disp_rdata, proc_rdata}, 0);
        chk("rst_hdr_valid", hdr_valid, 0);
        chk("rst_size", {img_width, img_height}, 0);

        // header load; display request already pending
        tick();
        rst = 1'b1;
        cyc = 0;
        header_check();

        // display stream, back-to-back grants
        for (int i = 1; i < 8; i++) begin
            tick();
            disp_addr = 18'(i);
            @(negedge clk);
            chk("stream_disp_gnt", disp_gnt, 1);
            chk("stream_proc_gnt", proc_gnt, 0);
            chk("stream_rdaddress", ram_rdaddress, 18'h10 + 18'(i - 1));
            push_d(18'h10 + 18'(i));
            last_addr = 18'h10 + 18'(i);
        end

        // starvation bound: D,D,D,D,P repeating
        begin
            string pat = "DDDDPDDDDP";
            logic [17:0] da = 18'h40;
            logic [17:0] pa = 18'h2_0100;
            for (int k = 0; k < 10; k++) begin
                tick();
                disp_req = 1'b1; disp_addr = da;
                proc_req = 1'b1; proc_addr = pa;
                @(negedge clk);
                chk("starve_rdaddress", ram_rdaddress, last_addr);
                if (pat[k] == "P") begin
                    chk("starve_proc_gnt", {disp_gnt, proc_gnt}, 2'b01);
                    push_p(pa);
                    last_addr = pa;
                    pa = pa + 18'h33;
                end else begin
                    chk("starve_disp_gnt", {disp_gnt, proc_gnt}, 2'b10);
                    push_d(da + 18'h10);
                    last_addr = da + 18'h10;
                    da = da + 18'd1;
                end
            end
        end

        // address wrap
        tick();
        proc_req = 1'b0;
        disp_addr = 18'h3FFF8;
        @(negedge clk);
        chk("wrap_gnt", disp_gnt, 1);
        push_d(18'h00008);
        tick();
        disp_req = 1'b0;
        @(negedge clk);
        chk("wrap_rdaddress", ram_rdaddress, 18'h00008);

        // idle: address holds, returns drain then stop
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            chk("idle_rdaddress", ram_rdaddress, 18'h00008);
            chk("idle_gnt", {disp_gnt, proc_gnt}, 0);
            if (i >= 3) chk("idle_rvalid", {disp_rvalid, proc_rvalid}, 0);
        end
        chk("drained_disp_q", dq.size(), 0);
        chk("drained_proc_q", pq.size(), 0);

        // reset mid-stream: in-flight reads must not return
        tick();
        disp_req = 1'b1;
        disp_addr = 18'h100;
        @(negedge clk);
        chk("pre_rst_gnt0", disp_gnt, 1);
        tick();
        disp_addr = 18'h101;
        @(negedge clk);
        chk("pre_rst_gnt1", disp_gnt, 1);
        tick();
        rst = 1'b0;
        disp_addr = 18'h102;
        @(negedge clk);
        chk("rst_cycle_gnt", disp_gnt, 0);
        tick();
        rst = 1'b1;
        cyc = 0;
        disp_addr = '0;
        header_check();

        tick();
        disp_req = 1'b0;
        repeat (RD_LAT + 4) tick();
        @(negedge clk);
        chk("final_disp_q", dq.size(), 0);
        chk("final_proc_q", pq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
